corevx_armleobus_ram_responder: RTL and testbench

//  Responder (slave) end of the armleobus single-transaction protocol; backs
//  the initiators (PTW, caches) with a word-addressed RAM window.

---
 rtl/corevx_armleobus_ram_responder_pkg.sv | 38 +++
 rtl/corevx_mem_1rw.sv | 31 +++
 rtl/corevx_armleobus_ram_responder.sv | 143 ++++++++++++++
 tb/tb_corevx_armleobus_ram_responder.sv | 398 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/corevx_armleobus_ram_responder_pkg.sv
// Shared armleobus command/response encodings and the request decoder used by
// the RAM responder.
package corevx_armleobus_ram_responder_pkg;

  localparam logic [2:0] ARMLEOBUS_CMD_NONE  = 3'd0;
  localparam logic [2:0] ARMLEOBUS_CMD_READ  = 3'd1;
  localparam logic [2:0] ARMLEOBUS_CMD_WRITE = 3'd2;

  localparam logic [2:0] ARMLEOBUS_RESPONSE_SUCCESS        = 3'd0;
  localparam logic [2:0] ARMLEOBUS_RESPONSE_UNKNOWNADDRESS = 3'd1;
  localparam logic [2:0] ARMLEOBUS_RESPONSE_MISSALIGNED    = 3'd2;
  localparam logic [2:0] ARMLEOBUS_RESPONSE_INVALIDCOMMAND = 3'd3;

  // Limit is computed one bit wider so a window ending at the top of the
  // 34-bit space does not wrap around to zero.
  function automatic logic [2:0] armleobus_decode(
    input logic [2:0]  cmd,
    input logic [33:0] address,
    input logic [33:0] base,
    input logic [34:0] size_bytes
  );
    logic [34:0] addr_ext;
    logic [34:0] limit;
    logic [2:0]  result;
    addr_ext = {1'b0, address};
    limit    = {1'b0, base} + size_bytes;
    if (cmd != ARMLEOBUS_CMD_READ && cmd != ARMLEOBUS_CMD_WRITE)
      result = ARMLEOBUS_RESPONSE_INVALIDCOMMAND;
    else if (address[1:0] != 2'b00)
      result = ARMLEOBUS_RESPONSE_MISSALIGNED;
    else if (addr_ext < {1'b0, base} || addr_ext >= limit)
      result = ARMLEOBUS_RESPONSE_UNKNOWNADDRESS;
    else
      result = ARMLEOBUS_RESPONSE_SUCCESS;
    return result;
  endfunction

endpackage

// File: rtl/corevx_mem_1rw.sv
// Single-port synchronous RAM with per-byte write strobes and a registered
// read port. Contents are never reset.
module corevx_mem_1rw #(
  parameter int WIDTH      = 32,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic [WIDTH/8-1:0]    wbyte_enable,
  output logic [WIDTH-1:0]      rdata
);

  logic [WIDTH-1:0] storage [0:(1<<DEPTH_LOG2)-1];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < WIDTH/8; i++) begin
          if (wbyte_enable[i])
            storage[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end else begin
        rdata <= storage[addr];
      end
    end
  end

endmodule

// File: rtl/corevx_armleobus_ram_responder.sv
// armleobus responder backed by a word-addressed RAM window: one transaction
// at a time, WAIT_CYCLES wait states, then a single-cycle done pulse.
module corevx_armleobus_ram_responder
  import corevx_armleobus_ram_responder_pkg::*;
#(
  parameter logic [33:0] BASE_ADDR   = 34'h0,
  parameter int          DEPTH_LOG2  = 10,
  parameter int          WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m_transaction,
  input  logic [2:0]  m_cmd,
  input  logic [33:0] m_address,
  input  logic [31:0] m_wdata,
  input  logic [3:0]  m_wbyte_enable,
  output logic [2:0]  m_transaction_response,
  output logic        m_transaction_done,
  output logic [31:0] m_rdata
);

  typedef enum logic [1:0] {
    STATE_IDLE,
    STATE_WAIT,
    STATE_RESPOND
  } state_t;

  localparam logic [34:0] SIZE_BYTES = 35'd4 << DEPTH_LOG2;
  localparam logic [3:0]  WAIT_LOAD  = 4'(WAIT_CYCLES);

  state_t                state;
  logic [3:0]            wait_cnt;
  logic                  done_q;
  logic [2:0]            resp_q;
  logic                  access_ok_q;
  logic                  is_write_q;
  logic                  read_ok_q;
  logic [DEPTH_LOG2-1:0] word_q;
  logic [31:0]           wdata_q;
  logic [3:0]            be_q;

  logic [2:0]            req_resp;
  logic [DEPTH_LOG2-1:0] req_word;
  logic                  accept;
  logic                  mem_en;
  logic                  mem_we;
  logic [DEPTH_LOG2-1:0] mem_addr;
  logic [31:0]           mem_wdata;
  logic [3:0]            mem_be;
  logic [31:0]           mem_rdata;

  // BASE_ADDR is aligned to the window size, so the low index bits of the
  // offset come straight from the address.
  assign req_resp = armleobus_decode(m_cmd, m_address, BASE_ADDR, SIZE_BYTES);
  assign req_word = m_address[DEPTH_LOG2+1:2] - BASE_ADDR[DEPTH_LOG2+1:2];
  assign accept   = (state == STATE_IDLE) && m_transaction;

  // The RAM access fires on the edge that enters RESPOND; with no wait
  // states that edge is the acceptance edge, so the live request feeds it.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = word_q;
    mem_wdata = wdata_q;
    mem_be    = be_q;
    if (WAIT_CYCLES == 0) begin
      mem_en    = !rst && accept && (req_resp == ARMLEOBUS_RESPONSE_SUCCESS);
      mem_we    = (m_cmd == ARMLEOBUS_CMD_WRITE);
      mem_addr  = req_word;
      mem_wdata = m_wdata;
      mem_be    = m_wbyte_enable;
    end else begin
      mem_en = !rst && (state == STATE_WAIT) && (wait_cnt == 4'd1) && access_ok_q;
      mem_we = is_write_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= STATE_IDLE;
      wait_cnt    <= 4'd0;
      done_q      <= 1'b0;
      resp_q      <= ARMLEOBUS_RESPONSE_SUCCESS;
      access_ok_q <= 1'b0;
      is_write_q  <= 1'b0;
      read_ok_q   <= 1'b0;
      word_q      <= '0;
      wdata_q     <= 32'h0;
      be_q        <= 4'h0;
    end else begin
      done_q <= 1'b0;
      case (state)
        STATE_IDLE: begin
          if (m_transaction) begin
            resp_q      <= req_resp;
            access_ok_q <= (req_resp == ARMLEOBUS_RESPONSE_SUCCESS);
            is_write_q  <= (m_cmd == ARMLEOBUS_CMD_WRITE);
            read_ok_q   <= (req_resp == ARMLEOBUS_RESPONSE_SUCCESS) &&
                           (m_cmd == ARMLEOBUS_CMD_READ);
            word_q      <= req_word;
            wdata_q     <= m_wdata;
            be_q        <= m_wbyte_enable;
            wait_cnt    <= WAIT_LOAD;
            if (WAIT_CYCLES == 0) begin
              state  <= STATE_RESPOND;
              done_q <= 1'b1;
            end else begin
              state <= STATE_WAIT;
            end
          end
        end
        STATE_WAIT: begin
          if (wait_cnt == 4'd1) begin
            state  <= STATE_RESPOND;
            done_q <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        STATE_RESPOND: state <= STATE_IDLE;
        default:       state <= STATE_IDLE;
      endcase
    end
  end

  corevx_mem_1rw #(
    .WIDTH      (32),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_mem (
    .clk          (clk),
    .en           (mem_en),
    .we           (mem_we),
    .addr         (mem_addr),
    .wdata        (mem_wdata),
    .wbyte_enable (mem_be),
    .rdata        (mem_rdata)
  );

  assign m_transaction_done     = done_q;
  assign m_transaction_response = resp_q;
  assign m_rdata                = (done_q && read_ok_q) ? mem_rdata : 32'h0;

endmodule

// File: tb/tb_corevx_armleobus_ram_responder.sv
// Bench for the armleobus RAM responder: one zero-wait instance and one
// three-wait instance sitting at the very top of the 34-bit address space.
module tb_corevx_armleobus_ram_responder;
  import corevx_armleobus_ram_responder_pkg::*;

  localparam logic [33:0] BASE0      = 34'h0_0000_1000;
  localparam logic [33:0] BASE1      = 34'h3_FFFF_F000;
  localparam int          DEPTH_LOG2 = 10;
  localparam int          WORDS      = 1 << DEPTH_LOG2;

  logic        clk = 1'b0;
  logic        rst [2];
  logic        m_transaction [2];
  logic [2:0]  m_cmd [2];
  logic [33:0] m_address [2];
  logic [31:0] m_wdata [2];
  logic [3:0]  m_wbyte_enable [2];
  logic [2:0]  m_transaction_response [2];
  logic        m_transaction_done [2];
  logic [31:0] m_rdata [2];

  int errors = 0;
  int checks = 0;

  logic [31:0] model [2][WORDS];
  bit          known [2][WORDS];

  always #5 clk = ~clk;

  corevx_armleobus_ram_responder #(
    .BASE_ADDR(BASE0), .DEPTH_LOG2(DEPTH_LOG2), .WAIT_CYCLES(0)
  ) dut0 (
    .clk(clk), .rst(rst[0]), .m_transaction(m_transaction[0]), .m_cmd(m_cmd[0]),
    .m_address(m_address[0]), .m_wdata(m_wdata[0]), .m_wbyte_enable(m_wbyte_enable[0]),
    .m_transaction_response(m_transaction_response[0]),
    .m_transaction_done(m_transaction_done[0]), .m_rdata(m_rdata[0])
  );

  corevx_armleobus_ram_responder #(
    .BASE_ADDR(BASE1), .DEPTH_LOG2(DEPTH_LOG2), .WAIT_CYCLES(3)
  ) dut1 (
    .clk(clk), .rst(rst[1]), .m_transaction(m_transaction[1]), .m_cmd(m_cmd[1]),
    .m_address(m_address[1]), .m_wdata(m_wdata[1]), .m_wbyte_enable(m_wbyte_enable[1]),
    .m_transaction_response(m_transaction_response[1]),
    .m_transaction_done(m_transaction_done[1]), .m_rdata(m_rdata[1])
  );

  function automatic logic [33:0] base_of(input int d);
    return (d == 0) ? BASE0 : BASE1;
  endfunction

  function automatic int wait_of(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  // Reference decode from the protocol rules, using plain integer arithmetic.
  function automatic logic [2:0] ref_response(input int d, input logic [2:0] cmd, input logic [33:0] addr);
    longint a;
    longint b;
    a = longint'(addr);
    b = longint'(base_of(d));
    if (cmd != ARMLEOBUS_CMD_READ && cmd != ARMLEOBUS_CMD_WRITE) return ARMLEOBUS_RESPONSE_INVALIDCOMMAND;
    if (a % 4 != 0) return ARMLEOBUS_RESPONSE_MISSALIGNED;
    if (a < b || a >= b + 4 * WORDS) return ARMLEOBUS_RESPONSE_UNKNOWNADDRESS;
    return ARMLEOBUS_RESPONSE_SUCCESS;
  endfunction

  task automatic model_txn(input int d, input logic [2:0] cmd, input logic [33:0] addr,
                           input logic [31:0] wdata, input logic [3:0] be,
                           output logic [2:0] er, output logic [31:0] ed);
    int idx;
    er = ref_response(d, cmd, addr);
    ed = 32'h0;
    if (er == ARMLEOBUS_RESPONSE_SUCCESS) begin
      idx = int'((longint'(addr) - longint'(base_of(d))) / 4);
      if (cmd == ARMLEOBUS_CMD_READ) begin
        ed = model[d][idx];
      end else begin
        for (int b = 0; b < 4; b++)
          if (be[b]) model[d][idx][8*b +: 8] = wdata[8*b +: 8];
        known[d][idx] = 1'b1;
      end
    end
  endtask

  task automatic run_txn(input int d, input logic [2:0] cmd, input logic [33:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be,
                         output logic [2:0] resp, output logic [31:0] rdata,
                         output int latency, output bit single);
    resp = 'x;
    rdata = 'x;
    latency = -1;
    @(posedge clk); #1;
    m_transaction[d] = 1'b1;
    m_cmd[d] = cmd;
    m_address[d] = addr;
    m_wdata[d] = wdata;
    m_wbyte_enable[d] = be;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (m_transaction_done[d]) begin
        latency = k;
        resp = m_transaction_response[d];
        rdata = m_rdata[d];
        break;
      end
    end
    m_transaction[d] = 1'b0;
    @(posedge clk); #1;
    single = (m_transaction_done[d] == 1'b0) && (m_rdata[d] == 32'h0);
  endtask

  task automatic test_reset;
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1;
      m_transaction[d] = 1'b0;
      m_cmd[d] = ARMLEOBUS_CMD_NONE;
      m_address[d] = 34'h0;
      m_wdata[d] = 32'h0;
      m_wbyte_enable[d] = 4'h0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (m_transaction_done[d] !== 1'b0 || m_transaction_response[d] !== ARMLEOBUS_RESPONSE_SUCCESS || m_rdata[d] !== 32'h0) begin
        errors++;
        $display("[TB] FAIL reset_state dut%0d: done=%b resp=%0d rdata=%h, expected done=0 resp=%0d rdata=0",
                 d, m_transaction_done[d], m_transaction_response[d], m_rdata[d], ARMLEOBUS_RESPONSE_SUCCESS);
      end
    end
    rst[0] = 1'b0;
    rst[1] = 1'b0;
  endtask

  task automatic test_basic;
    logic [2:0] r, er;
    logic [31:0] q, ed;
    int lat;
    bit one;
    model_txn(0, ARMLEOBUS_CMD_WRITE, 34'h1000, 32'hDEADBEEF, 4'hF, er, ed);
    run_txn(0, ARMLEOBUS_CMD_WRITE, 34'h1000, 32'hDEADBEEF, 4'hF, r, q, lat, one);
    checks++;
    if (r !== ARMLEOBUS_RESPONSE_SUCCESS || q !== 32'h0 || lat != 1 || !one) begin
      errors++;
      $display("[TB] FAIL basic_write: resp=%0d rdata=%h latency=%0d single=%b, expected resp=0 rdata=0 latency=1 single=1", r, q, lat, one);
    end
    model_txn(0, ARMLEOBUS_CMD_READ, 34'h1000, 32'h0, 4'h0, er, ed);
    run_txn(0, ARMLEOBUS_CMD_READ, 34'h1000, 32'h0, 4'h0, r, q, lat, one);
    checks++;
    if (r !== ARMLEOBUS_RESPONSE_SUCCESS || q !== 32'hDEADBEEF || lat != 1 || !one) begin
      errors++;
      $display("[TB] FAIL basic_read: resp=%0d rdata=%h latency=%0d single=%b, expected resp=0 rdata=deadbeef latency=1 single=1", r, q, lat, one);
    end
  endtask

  task automatic test_wait_latency;
    logic [2:0] r, er;
    logic [31:0] q, ed;
    int lat;
    bit one;
    model_txn(1, ARMLEOBUS_CMD_WRITE, BASE1 + 34'h40, 32'hCAFEF00D, 4'hF, er, ed);
    run_txn(1, ARMLEOBUS_CMD_WRITE, BASE1 + 34'h40, 32'hCAFEF00D, 4'hF, r, q, lat, one);
    checks++;
    if (r !== ARMLEOBUS_RESPONSE_SUCCESS || lat != 4 || !one) begin
      errors++;
      $display("[TB] FAIL wait_write: resp=%0d latency=%0d single=%b, expected resp=0 latency=4 single=1", r, lat, one);
    end
    model_txn(1, ARMLEOBUS_CMD_READ, BASE1 + 34'h40, 32'h0, 4'h0, er, ed);
    run_txn(1, ARMLEOBUS_CMD_READ, BASE1 + 34'h40, 32'h0, 4'h0, r, q, lat, one);
    checks++;
    if (r !== ARMLEOBUS_RESPONSE_SUCCESS || q !== 32'hCAFEF00D || lat != 4 || !one) begin
      errors++;
      $display("[TB] FAIL wait_read: resp=%0d rdata=%h latency=%0d single=%b, expected resp=0 rdata=cafef00d latency=4 single=1", r, q, lat, one);
    end
  endtask

  task automatic test_byte_enable;
    logic [2:0] r, er;
    logic [31:0] q, ed;
    int lat;
    bit one;
    model_txn(0, ARMLEOBUS_CMD_WRITE, 34'h1010, 32'h11223344, 4'hF, er, ed);
    run_txn(0, ARMLEOBUS_CMD_WRITE, 34'h1010, 32'h11223344, 4'hF, r, q, lat, one);
    model_txn(0, ARMLEOBUS_CMD_WRITE, 34'h1010, 32'hAABBCCDD, 4'b0101, er, ed);
    run_txn(0, ARMLEOBUS_CMD_WRITE, 34'h1010, 32'hAABBCCDD, 4'b0101, r, q, lat, one);
    model_txn(0, ARMLEOBUS_CMD_READ, 34'h1010, 32'h0, 4'h0, er, ed);
    run_txn(0, ARMLEOBUS_CMD_READ, 34'h1010, 32'h0, 4'h0, r, q, lat, one);
    checks++;
    if (r !== ARMLEOBUS_RESPONSE_SUCCESS || q !== 32'h11BB33DD) begin
      errors++;
      $display("[TB] FAIL byte_enable: resp=%0d rdata=%h, expected resp=0 rdata=11bb33dd", r, q);
    end
    model_txn(0, ARMLEOBUS_CMD_WRITE, 34'h1010, 32'h00000000, 4'h0, er, ed);
    run_txn(0, ARMLEOBUS_CMD_WRITE, 34'h1010, 32'h00000000, 4'h0, r, q, lat, one);
    checks++;
    if (r !== ARMLEOBUS_RESPONSE_SUCCESS) begin
      errors++;
      $display("[TB] FAIL empty_strobe_resp: resp=%0d, expected resp=0", r);
    end
    model_txn(0, ARMLEOBUS_CMD_READ, 34'h1010, 32'h0, 4'h0, er, ed);
    run_txn(0, ARMLEOBUS_CMD_READ, 34'h1010, 32'h0, 4'h0, r, q, lat, one);
    checks++;
    if (q !== 32'h11BB33DD) begin
      errors++;
      $display("[TB] FAIL empty_strobe_data: rdata=%h, expected rdata=11bb33dd", q);
    end
  endtask

  task automatic test_errors;
    logic [2:0] r, er;
    logic [31:0] q, ed;
    int lat;
    bit one;
    logic [2:0]  cmds [6];
    logic [33:0] addrs [6];
    logic [2:0]  exps [6];
    int          devs [6];
    cmds  = '{ARMLEOBUS_CMD_READ, ARMLEOBUS_CMD_READ, 3'b111, ARMLEOBUS_CMD_WRITE, ARMLEOBUS_CMD_READ, ARMLEOBUS_CMD_NONE};
    addrs = '{34'h1002, 34'h2000, 34'h1000, 34'h0FFC, 34'h3_FFFF_EFFC, BASE1};
    exps  = '{ARMLEOBUS_RESPONSE_MISSALIGNED, ARMLEOBUS_RESPONSE_UNKNOWNADDRESS,
              ARMLEOBUS_RESPONSE_INVALIDCOMMAND, ARMLEOBUS_RESPONSE_UNKNOWNADDRESS,
              ARMLEOBUS_RESPONSE_UNKNOWNADDRESS, ARMLEOBUS_RESPONSE_INVALIDCOMMAND};
    devs  = '{0, 0, 0, 0, 1, 1};
    for (int i = 0; i < 6; i++) begin
      model_txn(devs[i], cmds[i], addrs[i], 32'h5A5A5A5A, 4'hF, er, ed);
      run_txn(devs[i], cmds[i], addrs[i], 32'h5A5A5A5A, 4'hF, r, q, lat, one);
      checks++;
      if (r !== exps[i] || q !== 32'h0 || lat != wait_of(devs[i]) + 1) begin
        errors++;
        $display("[TB] FAIL error_case%0d: resp=%0d rdata=%h latency=%0d, expected resp=%0d rdata=0 latency=%0d",
                 i, r, q, lat, exps[i], wait_of(devs[i]) + 1);
      end
    end
    model_txn(0, ARMLEOBUS_CMD_READ, 34'h1000, 32'h0, 4'h0, er, ed);
    run_txn(0, ARMLEOBUS_CMD_READ, 34'h1000, 32'h0, 4'h0, r, q, lat, one);
    checks++;
    if (r !== ARMLEOBUS_RESPONSE_SUCCESS || q !== 32'hDEADBEEF) begin
      errors++;
      $display("[TB] FAIL error_ram_intact: resp=%0d rdata=%h, expected resp=0 rdata=deadbeef", r, q);
    end
    model_txn(1, ARMLEOBUS_CMD_WRITE, 34'h3_FFFF_FFFC, 32'h0BADCAFE, 4'hF, er, ed);
    run_txn(1, ARMLEOBUS_CMD_WRITE, 34'h3_FFFF_FFFC, 32'h0BADCAFE, 4'hF, r, q, lat, one);
    model_txn(1, ARMLEOBUS_CMD_READ, 34'h3_FFFF_FFFC, 32'h0, 4'h0, er, ed);
    run_txn(1, ARMLEOBUS_CMD_READ, 34'h3_FFFF_FFFC, 32'h0, 4'h0, r, q, lat, one);
    checks++;
    if (r !== ARMLEOBUS_RESPONSE_SUCCESS || q !== 32'h0BADCAFE) begin
      errors++;
      $display("[TB] FAIL top_word: resp=%0d rdata=%h, expected resp=0 rdata=0badcafe", r, q);
    end
  endtask

  task automatic test_back_to_back(input int d);
    logic [2:0] r, er;
    logic [31:0] q, ed;
    int lat, exp_lat;
    bit one;
    logic [33:0] b;
    logic [2:0]  cmds [3];
    logic [33:0] addrs [3];
    logic [31:0] wds [3];
    b = base_of(d);
    model_txn(d, ARMLEOBUS_CMD_WRITE, b + 34'h24, 32'h24242424 ^ 32'(d), 4'hF, er, ed);
    run_txn(d, ARMLEOBUS_CMD_WRITE, b + 34'h24, 32'h24242424 ^ 32'(d), 4'hF, r, q, lat, one);
    cmds  = '{ARMLEOBUS_CMD_WRITE, ARMLEOBUS_CMD_READ, ARMLEOBUS_CMD_READ};
    addrs = '{b + 34'h20, b + 34'h20, b + 34'h24};
    wds   = '{$urandom, 32'h0, 32'h0};
    @(posedge clk); #1;
    m_transaction[d] = 1'b1;
    for (int t = 0; t < 3; t++) begin
      m_cmd[d] = cmds[t];
      m_address[d] = addrs[t];
      m_wdata[d] = wds[t];
      m_wbyte_enable[d] = 4'hF;
      model_txn(d, cmds[t], addrs[t], wds[t], 4'hF, er, ed);
      r = 'x;
      q = 'x;
      lat = -1;
      for (int k = 1; k <= 40; k++) begin
        @(posedge clk); #1;
        if (m_transaction_done[d]) begin
          lat = k;
          r = m_transaction_response[d];
          q = m_rdata[d];
          break;
        end
      end
      exp_lat = (t == 0) ? wait_of(d) + 1 : wait_of(d) + 2;
      checks++;
      if (r !== er || q !== ed || lat != exp_lat) begin
        errors++;
        $display("[TB] FAIL back_to_back dut%0d step%0d: resp=%0d rdata=%h latency=%0d, expected resp=%0d rdata=%h latency=%0d",
                 d, t, r, q, lat, er, ed, exp_lat);
      end
    end
    m_transaction[d] = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (m_transaction_done[d] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL back_to_back_end dut%0d: done=%b, expected done=0", d, m_transaction_done[d]);
    end
  endtask

  task automatic test_reset_mid;
    logic [2:0] r, er;
    logic [31:0] q, ed;
    int lat;
    bit one;
    bit saw_done;
    model_txn(1, ARMLEOBUS_CMD_WRITE, BASE1 + 34'h80, 32'h12345678, 4'hF, er, ed);
    run_txn(1, ARMLEOBUS_CMD_WRITE, BASE1 + 34'h80, 32'h12345678, 4'hF, r, q, lat, one);
    @(posedge clk); #1;
    m_transaction[1] = 1'b1;
    m_cmd[1] = ARMLEOBUS_CMD_WRITE;
    m_address[1] = BASE1 + 34'h80;
    m_wdata[1] = 32'hFFFFFFFF;
    m_wbyte_enable[1] = 4'hF;
    @(posedge clk); #1;
    saw_done = m_transaction_done[1];
    @(posedge clk); #1;
    saw_done |= m_transaction_done[1];
    rst[1] = 1'b1;
    m_transaction[1] = 1'b0;
    @(posedge clk); #1;
    saw_done |= m_transaction_done[1];
    rst[1] = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      saw_done |= m_transaction_done[1];
    end
    checks++;
    if (saw_done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_mid_done: done seen=%b, expected 0", saw_done);
    end
    model_txn(1, ARMLEOBUS_CMD_READ, BASE1 + 34'h80, 32'h0, 4'h0, er, ed);
    run_txn(1, ARMLEOBUS_CMD_READ, BASE1 + 34'h80, 32'h0, 4'h0, r, q, lat, one);
    checks++;
    if (r !== ARMLEOBUS_RESPONSE_SUCCESS || q !== 32'h12345678 || lat != 4) begin
      errors++;
      $display("[TB] FAIL reset_mid_word: resp=%0d rdata=%h latency=%0d, expected resp=0 rdata=12345678 latency=4", r, q, lat);
    end
  endtask

  task automatic test_random;
    for (int n = 0; n < 80; n++) begin
      int d, cat, idx, lat;
      logic [33:0] b, addr;
      logic [2:0] cmd, r, er;
      logic [3:0] be;
      logic [31:0] wd, q, ed;
      bit one;
      d   = int'($urandom_range(0, 1));
      b   = base_of(d);
      cat = int'($urandom_range(0, 9));
      idx = int'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) idx += WORDS - 16;
      addr = b + 34'(idx * 4);
      cmd  = ($urandom_range(0, 1) == 1) ? ARMLEOBUS_CMD_READ : ARMLEOBUS_CMD_WRITE;
      be   = 4'($urandom);
      wd   = $urandom;
      if (cat == 0)
        cmd = ($urandom_range(0, 1) == 1) ? ARMLEOBUS_CMD_NONE : 3'($urandom_range(3, 7));
      else if (cat == 1)
        addr = addr + 34'($urandom_range(1, 3));
      else if (cat == 2)
        addr = (d == 0) ? b + 34'h1000 + 34'(4 * $urandom_range(0, 255)) : b - 34'(4 * $urandom_range(1, 256));
      else if (!known[d][idx]) begin
        cmd = ARMLEOBUS_CMD_WRITE;
        be  = 4'hF;
      end
      model_txn(d, cmd, addr, wd, be, er, ed);
      run_txn(d, cmd, addr, wd, be, r, q, lat, one);
      checks++;
      if (r !== er || q !== ed || lat != wait_of(d) + 1 || !one) begin
        errors++;
        $display("[TB] FAIL random%0d dut%0d cmd=%0d addr=%h: resp=%0d rdata=%h latency=%0d single=%b, expected resp=%0d rdata=%h latency=%0d single=1",
                 n, d, cmd, addr, r, q, lat, one, er, ed, wait_of(d) + 1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wait_latency();
    test_byte_enable();
    test_errors();
    test_back_to_back(0);
    test_back_to_back(1);
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
